pcm_pwm_sink: RTL and testbench

Consumer end of the bytebeat sample stream: accepts 8-bit PCM samples over a valid/ready channel and paces them at a fixed audio sample rate derived from the system clock. Each accepted sample drives a 1-bit PWM audio output for one sample period and is also presented as a parallel byte. The block sits between a `bytebeat` generator's `output_s` channel and the output pins. It backpressures the generator so one sample is taken per sample period, and it flags underruns.

---
 rtl/pcm_pwm_sink.sv | 106 ++++++++++
 tb/tb_pcm_pwm_sink.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pcm_pwm_sink.sv
// PCM sample sink: paces 8-bit samples at 256*PWM_PER_SAMPLE clocks per sample and drives 1-bit PWM audio.
// Optional macro PCM_PWM_SINK_SIGMA_DELTA_EN swaps the comparator PWM for a first-order sigma-delta modulator.
module pcm_pwm_sink #(
  parameter int unsigned PWM_PER_SAMPLE = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pcm,
  input  logic       pcm_vld,
  output logic       pcm_rdy,
  output logic       pwm_out,
  output logic [7:0] sample_out,
  output logic       underrun,
  output logic [7:0] underrun_cnt
);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [7:0] REP_LAST = 8'(PWM_PER_SAMPLE - 1);

  state_t     state;
  logic [7:0] pwm_cnt;
  logic [7:0] rep_cnt;
  logic [7:0] pending;
  logic [7:0] active;
  logic       boundary;
  logic       handshake;

  // pcm_rdy is a function of state and reset only, so it never depends on pcm_vld.
  always_comb begin
    boundary  = (pwm_cnt == 8'hFF) && (rep_cnt == REP_LAST);
    pcm_rdy   = (state == ST_WAIT) && !reset;
    handshake = pcm_vld && pcm_rdy;
  end

  assign sample_out = active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        if (rep_cnt == REP_LAST) rep_cnt <= '0;
        else                     rep_cnt <= rep_cnt + 8'd1;
      end
    end
  end

  // active only moves on the boundary edge, so a new duty always starts at pwm_cnt == 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_WAIT;
      pending      <= '0;
      active       <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      unique case (state)
        ST_WAIT: begin
          if (handshake && boundary) begin
            active <= pcm;
          end else if (handshake) begin
            pending <= pcm;
            state   <= ST_FULL;
          end else if (boundary) begin
            underrun <= 1'b1;
            if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
        ST_FULL: begin
          if (boundary) begin
            active <= pending;
            state  <= ST_WAIT;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

`ifdef PCM_PWM_SINK_SIGMA_DELTA_EN
  logic [8:0] acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[7:0]} + {1'b0, active};
      pwm_out <= acc[8];
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= (pwm_cnt < active);
  end
`endif

endmodule

// File: tb/tb_pcm_pwm_sink.sv
// Directed bench for pcm_pwm_sink: pacing, PWM duty, underrun, boundary transfer, saturation and mid-run reset.
module tb_pcm_pwm_sink;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pcm = '0;
  logic       pcm_vld = 1'b0;
  logic       pcm_rdy, pwm_out, underrun;
  logic [7:0] sample_out, underrun_cnt;

  logic [7:0] s_pcm = '0;
  logic       s_vld = 1'b0;
  logic       s_rdy, s_pwm, s_und;
  logic [7:0] s_sample, s_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int e = 0;

  always #5 clk = ~clk;

  pcm_pwm_sink #(.PWM_PER_SAMPLE(2)) dut (
    .clk(clk), .reset(reset), .pcm(pcm), .pcm_vld(pcm_vld), .pcm_rdy(pcm_rdy),
    .pwm_out(pwm_out), .sample_out(sample_out), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  pcm_pwm_sink #(.PWM_PER_SAMPLE(1)) dut_sat (
    .clk(clk), .reset(reset), .pcm(s_pcm), .pcm_vld(s_vld), .pcm_rdy(s_rdy),
    .pwm_out(s_pwm), .sample_out(s_sample), .underrun(s_und), .underrun_cnt(s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts pwm_out highs over the 256 edges following the current one.
  task automatic count_window(output int highs, output int alt_errs);
    logic prev;
    highs = 0;
    alt_errs = 0;
    prev = pwm_out;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pwm_out) highs++;
      if (pwm_out === prev) alt_errs++;
      prev = pwm_out;
    end
  endtask

  initial begin
    int highs;
    int alt_errs;
    int pat_errs;

    pcm = 8'h55;
    pcm_vld = 1'b1;
    repeat (5) step();
    chk("reset_rdy", 32'(pcm_rdy), 0);
    chk("reset_pwm", 32'(pwm_out), 0);
    chk("reset_sample", 32'(sample_out), 0);
    chk("reset_underrun", 32'(underrun), 0);
    chk("reset_cnt", 32'(underrun_cnt), 0);

    pcm_vld = 1'b0;
    reset = 1'b0;
    e = 0;
    step();
    chk("rdy_after_release", 32'(pcm_rdy), 1);
    chk("sample_after_release", 32'(sample_out), 0);

    // Offer 0x40 mid-period; it plays for the whole following period.
    run_to(10);
    pcm = 8'h40;
    pcm_vld = 1'b1;
    step();
    pcm_vld = 1'b0;
    chk("rdy_drop_after_accept", 32'(pcm_rdy), 0);
    chk("sample_before_boundary_early", 32'(sample_out), 0);
    run_to(511);
    chk("sample_before_boundary", 32'(sample_out), 0);
    step();
    chk("sample_at_boundary", 32'(sample_out), 32'h40);
    chk("rdy_after_boundary", 32'(pcm_rdy), 1);
    chk("no_underrun_full", 32'(underrun), 0);

`ifndef PCM_PWM_SINK_SIGMA_DELTA_EN
    // Comparator: pwm_out after edge k reflects pwm_cnt == (k-1) mod 256.
    pat_errs = 0;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pwm_out) highs++;
      if (pwm_out !== ((((e - 1) & 255) < 64) ? 1'b1 : 1'b0)) pat_errs++;
    end
    chk("duty40_highs", 32'(highs), 64);
    chk("duty40_pattern_errs", 32'(pat_errs), 0);
`else
    run_to(514);
    count_window(highs, alt_errs);
    chk("duty40_highs", 32'(highs), 64);
`endif

    run_to(1023);
    chk("no_underrun_before", 32'(underrun), 0);
    step();
    chk("underrun_pulse", 32'(underrun), 1);
    chk("underrun_cnt_1", 32'(underrun_cnt), 1);
    chk("sample_held_underrun", 32'(sample_out), 32'h40);
    step();
    chk("underrun_one_cycle", 32'(underrun), 0);

    // Handshake only on the boundary cycle goes straight to active.
    run_to(1535);
    pcm = 8'h80;
    pcm_vld = 1'b1;
    step();
    pcm_vld = 1'b0;
    chk("bnd_sample", 32'(sample_out), 32'h80);
    chk("bnd_no_underrun", 32'(underrun), 0);
    chk("bnd_rdy", 32'(pcm_rdy), 1);
    chk("bnd_cnt_unchanged", 32'(underrun_cnt), 1);

    run_to(1538);
    count_window(highs, alt_errs);
    chk("duty80_highs", 32'(highs), 128);
`ifdef PCM_PWM_SINK_SIGMA_DELTA_EN
    chk("sd80_alternation_errs", 32'(alt_errs), 0);
`endif

    run_to(1800);
    pcm = 8'h00;
    pcm_vld = 1'b1;
    step();
    pcm_vld = 1'b0;
    chk("rdy_drop_00", 32'(pcm_rdy), 0);
    run_to(2050);
    chk("sample_00", 32'(sample_out), 0);
    count_window(highs, alt_errs);
    chk("duty00_highs", 32'(highs), 0);

    run_to(2310);
    pcm = 8'hFF;
    pcm_vld = 1'b1;
    step();
    pcm_vld = 1'b0;
    run_to(2562);
    chk("sample_ff", 32'(sample_out), 32'hFF);
    count_window(highs, alt_errs);
    chk("dutyff_highs", 32'(highs), 255);
    chk("underrun_cnt_still_1", 32'(underrun_cnt), 1);

    // dut_sat has underrun at every 256-clock boundary since release.
    run_to(256 * 254);
    chk("sat_cnt_254", 32'(s_cnt), 254);
    run_to(256 * 255);
    chk("sat_cnt_255", 32'(s_cnt), 255);
    run_to(256 * 260);
    chk("sat_cnt_held", 32'(s_cnt), 255);
    chk("sat_pulse_after_sat", 32'(s_und), 1);

    s_pcm = 8'h99;
    s_vld = 1'b1;
    step();
    s_vld = 1'b0;
    chk("sat_full_rdy", 32'(s_rdy), 0);
    run_to(e + 10);
    reset = 1'b1;
    #1;
    chk("midreset_cnt", 32'(s_cnt), 0);
    chk("midreset_rdy", 32'(s_rdy), 0);
    chk("midreset_sample", 32'(s_sample), 0);
    chk("midreset_main_cnt", 32'(underrun_cnt), 0);
    step();
    step();
    reset = 1'b0;
    e = 0;
    step();
    chk("midreset_rdy_release", 32'(s_rdy), 1);
    run_to(256);
    chk("discard_underrun", 32'(s_und), 1);
    chk("discard_cnt", 32'(s_cnt), 1);
    chk("discard_sample", 32'(s_sample), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
